// File: rtl/regfile_bist_pkg.sv
// regfile_bist_pkg: shared sizes, FSM encodings, compare request and data-pattern helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package regfile_bist_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ERR_W    = 8;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PRECHECK = 3'd1;
  localparam logic [2:0] WRITE    = 3'd2;
  localparam logic [2:0] RADDR    = 3'd3;
  localparam logic [2:0] RWAIT    = 3'd4;
  localparam logic [2:0] RCHECK   = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  // One dual-port readback sample handed to the comparator.
  typedef struct packed {
    logic [ADDR_W-1:0] addrA;
    logic [ADDR_W-1:0] addrB;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic [DATA_W-1:0] expA;
    logic [DATA_W-1:0] expB;
  } cmpReq_t;

  // Data written to register addr: walking one, address, or walking zero.
  function automatic logic [DATA_W-1:0] pattern(input int mode, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] walkOne;
    walkOne = {{(DATA_W-1){1'b0}}, 1'b1} << addr;
    case (mode)
      1:       pattern = {{(DATA_W-ADDR_W){1'b0}}, addr};
      2:       pattern = ~walkOne;
      default: pattern = walkOne;
    endcase
  endfunction

  // Readback expectation: register 0 is hardwired to zero, and the precheck pass expects all zero.
  function automatic logic [DATA_W-1:0] expected(input int mode, input logic [ADDR_W-1:0] addr,
                                                 input logic zeroAll);
    if (zeroAll || addr == '0) expected = '0;
    else                       expected = pattern(mode, addr);
  endfunction

endpackage

// File: rtl/regfile_bist_cmp.sv
// regfile_bist_cmp: compares both read ports against expected data and tallies mismatches.
// Latency: mismatch flags 1 cycle after checkEn; errorCount/first-fail 2 cycles after.
// Backpressure: none; accepts one dual-port compare every cycle.
module regfile_bist_cmp
  import regfile_bist_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              clear,
  input  logic              checkEn,
  input  cmpReq_t           req,
  output logic [ERR_W-1:0]  errorCount,
  output logic              failValid,
  output logic [ADDR_W-1:0] failReg
);

  logic              mismatch_a;
  logic              mismatch_b;
  logic [ADDR_W-1:0] addrA;
  logic [ADDR_W-1:0] addrB;
  logic [1:0]        hits;
  logic [ERR_W:0]    sum;

  // Stage 1: per-port mismatch flags (case inequality so X/Z reads count as errors) plus addresses.
  always_ff @(posedge clock) begin
    if (ctrl_reset || clear) begin
      mismatch_a <= 1'b0;
      mismatch_b <= 1'b0;
      addrA      <= '0;
      addrB      <= '0;
    end else begin
      mismatch_a <= checkEn && (req.dataA !== req.expA);
      mismatch_b <= checkEn && (req.dataB !== req.expB);
      addrA      <= req.addrA;
      addrB      <= req.addrB;
    end
  end

  assign hits = {1'b0, mismatch_a} + {1'b0, mismatch_b};
  assign sum  = {1'b0, errorCount} + {{(ERR_W-1){1'b0}}, hits};

  // Stage 2: saturating error tally and first-failure capture, port A taking priority over B.
  always_ff @(posedge clock) begin
    if (ctrl_reset || clear) begin
      errorCount <= '0;
      failValid  <= 1'b0;
      failReg    <= '0;
    end else begin
      errorCount <= sum[ERR_W] ? '1 : sum[ERR_W-1:0];
      if (!failValid && (mismatch_a || mismatch_b)) begin
        failValid <= 1'b1;
        failReg   <= mismatch_a ? addrA : addrB;
      end
    end
  end

endmodule

// File: rtl/regfile_bist.sv
// regfile_bist: writes a pattern to all 32 registers, reads each back on both ports, reports result.
// Latency: start to done = 1 + 32 + 32*(READ_LATENCY+1) cycles; REGFILE_BIST_RESET_CHECK_EN adds a precheck read pass.
// Backpressure: none; start is ignored while busy, and held-high start re-runs after each done cycle.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int PATTERN_MODE = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  output logic              ctrl_writeEn,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [ADDR_W-1:0] ctrl_readRegA,
  output logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_reg
);

  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(READ_LATENCY - 2);

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        waitCnt;
  logic              preCheck;
  logic              runStart;
  cmpReq_t           cmpReq;

  // A run may launch from IDLE, or from DONE once done has been shown for at least one cycle.
  assign runStart = start && ((state == IDLE) || ((state == DONE) && done));

  assign pass = done && (error_count == '0);

  assign cmpReq.addrA = ctrl_readRegA;
  assign cmpReq.addrB = ctrl_readRegB;
  assign cmpReq.dataA = data_readRegA;
  assign cmpReq.dataB = data_readRegB;
  assign cmpReq.expA  = expected(PATTERN_MODE, ctrl_readRegA, preCheck);
  assign cmpReq.expB  = expected(PATTERN_MODE, ctrl_readRegB, preCheck);

  // Sequencer: write sweep, then per-index address / wait / check, then done.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state         <= IDLE;
      idx           <= '0;
      waitCnt       <= '0;
      preCheck      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      ctrl_readRegA <= '0;
      ctrl_readRegB <= '0;
    end else if (runStart) begin
      busy <= 1'b1;
      done <= 1'b0;
      idx  <= '0;
`ifdef REGFILE_BIST_RESET_CHECK_EN
      preCheck <= 1'b1;
      state    <= RADDR;
`else
      preCheck <= 1'b0;
      state    <= WRITE;
`endif
    end else begin
      case (state)
        WRITE: begin
          ctrl_writeEn  <= 1'b1;
          ctrl_writeReg <= idx;
          data_writeReg <= pattern(PATTERN_MODE, idx);
          idx           <= idx + 1'b1;
          if (idx == LAST_REG) state <= RADDR;
        end
        RADDR: begin
          ctrl_writeEn  <= 1'b0;
          ctrl_writeReg <= '0;
          data_writeReg <= '0;
          ctrl_readRegA <= idx;
          ctrl_readRegB <= LAST_REG - idx;
          waitCnt       <= '0;
          state         <= (READ_LATENCY > 1) ? RWAIT : RCHECK;
        end
        RWAIT: begin
          waitCnt <= waitCnt + 1'b1;
          if (waitCnt == WAIT_LAST) state <= RCHECK;
        end
        RCHECK: begin
          if (idx == LAST_REG) begin
            idx <= '0;
            if (preCheck) begin
              preCheck <= 1'b0;
              state    <= WRITE;
            end else begin
              state <= DONE;
            end
          end else begin
            idx   <= idx + 1'b1;
            state <= RADDR;
          end
        end
        DONE: begin
          // First DONE cycle lets the final compare drain before done/pass are shown.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= state;
      endcase
    end
  end

  regfile_bist_cmp u_cmp (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .clear      (runStart),
    .checkEn    (state == RCHECK),
    .req        (cmpReq),
    .errorCount (error_count),
    .failValid  (fail_valid),
    .failReg    (fail_reg)
  );

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: drives two BIST instances against behavioural regfiles with injectable faults.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_bist;

`ifdef REGFILE_BIST_RESET_CHECK_EN
  localparam int PRE0 = 64;
  localparam int PRE1 = 128;
  localparam int STUCK_PRE = 2;
  localparam logic [16:0] T6_EXP = {1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 5'd3};
`else
  localparam int PRE0 = 0;
  localparam int PRE1 = 0;
  localparam int STUCK_PRE = 0;
  localparam logic [16:0] T6_EXP = {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 5'd0};
`endif
  localparam int LEN0 = 1 + 32 + 32 * (1 + 1) + PRE0;
  localparam int LEN1 = 1 + 32 + 32 * (3 + 1) + PRE1;
  // status = {busy, done, pass, fail_valid, error_count, fail_reg}
  localparam logic [16:0] CLEAN = {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 5'd0};

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        ctrlReset;
  logic        start0, we0, busy0, done0, pass0, fv0;
  logic [4:0]  wr0, ra0, rb0, fr0;
  logic [31:0] wd0, rdA0, rdB0;
  logic [7:0]  ec0;
  logic        start1, we1, busy1, done1, pass1, fv1;
  logic [4:0]  wr1, ra1, rb1, fr1;
  logic [31:0] wd1, rdA1, rdB1;
  logic [7:0]  ec1;

  logic        rfClear, pokeEn, faultReg0, stuckBit7;
  logic [4:0]  pokeAddr;
  logic [31:0] pokeData;
  logic [31:0] rf0 [32];
  logic [31:0] rf1 [32];

  wr_t q0[$];
  wr_t q1[$];
  wr_t exp0, exp1;
  int  passCnt = 0;
  int  failCnt = 0;
  int  totalCnt = 0;

  regfile_bist #(.PATTERN_MODE(0), .READ_LATENCY(1)) dut0 (
    .clock(clock), .ctrl_reset(ctrlReset), .start(start0),
    .ctrl_writeEn(we0), .ctrl_writeReg(wr0), .data_writeReg(wd0),
    .ctrl_readRegA(ra0), .ctrl_readRegB(rb0), .data_readRegA(rdA0), .data_readRegB(rdB0),
    .busy(busy0), .done(done0), .pass(pass0), .error_count(ec0), .fail_valid(fv0), .fail_reg(fr0)
  );

  regfile_bist #(.PATTERN_MODE(1), .READ_LATENCY(3)) dut1 (
    .clock(clock), .ctrl_reset(ctrlReset), .start(start1),
    .ctrl_writeEn(we1), .ctrl_writeReg(wr1), .data_writeReg(wd1),
    .ctrl_readRegA(ra1), .ctrl_readRegB(rb1), .data_readRegA(rdA1), .data_readRegB(rdB1),
    .busy(busy1), .done(done1), .pass(pass1), .error_count(ec1), .fail_valid(fv1), .fail_reg(fr1)
  );

  // Behavioural regfiles: reg 0 ignores writes unless faultReg0; combinational reads.
  always @(posedge clock) begin
    if (rfClear) begin
      for (int i = 0; i < 32; i++) begin
        rf0[i] <= 32'd0;
        rf1[i] <= 32'd0;
      end
    end else begin
      if (pokeEn) rf0[pokeAddr] <= pokeData;
      if (we0 && (wr0 != 5'd0 || faultReg0)) rf0[wr0] <= wd0;
      if (we1 && wr1 != 5'd0) rf1[wr1] <= wd1;
    end
  end

  assign rdA0 = rf0[ra0];
  assign rdB0 = rf0[rb0];
  assign rdA1 = rf1[ra1] | ((stuckBit7 && ra1 == 5'd5) ? 32'h80 : 32'h0);
  assign rdB1 = rf1[rb1] | ((stuckBit7 && rb1 == 5'd5) ? 32'h80 : 32'h0);

  function automatic logic [31:0] tbPattern(int mode, int i);
    logic [31:0] w;
    w = 32'h1 << i;
    if (mode == 1) return 32'(i);
    if (mode == 2) return ~w;
    return w;
  endfunction

  function automatic logic [16:0] status(int which);
    if (which == 0) return {busy0, done0, pass0, fv0, ec0, fr0};
    return {busy1, done1, pass1, fv1, ec1, fr1};
  endfunction

  function automatic logic [47:0] ports(int which);
    if (which == 0) return {we0, wr0, ra0, rb0, wd0};
    return {we1, wr1, ra1, rb1, wd1};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every observed write must match the next expected entry.
  always @(negedge clock) begin
    if (we0) begin
      check("dut0 write expected", 64'(we0), 64'(q0.size() != 0));
      if (q0.size() != 0) begin
        exp0 = q0.pop_front();
        check("dut0 write addr/data", 64'({wr0, wd0}), 64'(exp0));
      end
    end
    if (we1) begin
      check("dut1 write expected", 64'(we1), 64'(q1.size() != 0));
      if (q1.size() != 0) begin
        exp1 = q1.pop_front();
        check("dut1 write addr/data", 64'({wr1, wd1}), 64'(exp1));
      end
    end
  end

  task automatic clearRf();
    rfClear = 1'b1;
    @(posedge clock); #1;
    rfClear = 1'b0;
  endtask

  task automatic pushWrites(input int which);
    for (int i = 0; i < 32; i++) begin
      if (which == 0) q0.push_back(wr_t'{addr: 5'(i), data: tbPattern(0, i)});
      else            q1.push_back(wr_t'{addr: 5'(i), data: tbPattern(1, i)});
    end
  endtask

  task automatic runDut(input int which, input bit pulses, input bit preload3, output int cycles);
    clearRf();
    if (preload3) begin
      pokeEn = 1'b1; pokeAddr = 5'd3; pokeData = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      pokeEn = 1'b0;
    end
    pushWrites(which);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0;
    check(which == 0 ? "dut0 launch status" : "dut1 launch status",
          64'(status(which)), 64'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0}));
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
      if (pulses) begin
        if (which == 0) start0 = (cycles == 20 || cycles == 60);
        else            start1 = (cycles == 20 || cycles == 60);
      end
    end while (!(which == 0 ? done0 : done1) && cycles < 2000);
    start0 = 1'b0; start1 = 1'b0;
    check(which == 0 ? "dut0 run length" : "dut1 run length",
          64'(cycles), 64'(which == 0 ? LEN0 : LEN1));
    check(which == 0 ? "dut0 writes drained" : "dut1 writes drained",
          64'(which == 0 ? q0.size() : q1.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    ctrlReset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    rfClear = 1'b1; pokeEn = 1'b0; pokeAddr = 5'd0; pokeData = 32'd0;
    faultReg0 = 1'b0; stuckBit7 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset dut0 status", 64'(status(0)), 64'd0);
    check("reset dut0 ports",  64'(ports(0)),  64'd0);
    check("reset dut1 status", 64'(status(1)), 64'd0);
    check("reset dut1 ports",  64'(ports(1)),  64'd0);
    ctrlReset = 1'b0; rfClear = 1'b0;

    // Clean regfile, walking ones.
    runDut(0, 1'b0, 1'b0, cyc);
    check("t1 status", 64'(status(0)), 64'(CLEAN));
    repeat (4) @(posedge clock);
    #1;
    check("t1 done sticky", 64'(status(0)), 64'(CLEAN));
    check("t1 idle ports", 64'(ports(0)), 64'({1'b0, 5'd0, 5'd31, 5'd0, 32'd0}));

    // Restart from done with extra start pulses mid-run.
    runDut(0, 1'b1, 1'b0, cyc);
    check("t5 rerun status", 64'(status(0)), 64'(CLEAN));

    // Register 0 wrongly stores writes.
    faultReg0 = 1'b1;
    runDut(0, 1'b0, 1'b0, cyc);
    check("t2 reg0 fault", 64'(status(0)), 64'({1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 5'd0}));
    faultReg0 = 1'b0;

    // Bit 7 of register 5 stuck high, address pattern, read latency 3.
    stuckBit7 = 1'b1;
    runDut(1, 1'b0, 1'b0, cyc);
    check("t3 stuck bit", 64'(status(1)), 64'({1'b0, 1'b1, 1'b0, 1'b1, 8'(2 + STUCK_PRE), 5'd5}));
    stuckBit7 = 1'b0;
    runDut(1, 1'b0, 1'b0, cyc);
    check("t3 clean rerun", 64'(status(1)), 64'(CLEAN));

    // Reset during the check of index 10.
    clearRf();
    pushWrites(0);
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    repeat (53 + PRE0) @(posedge clock);
    #1;
    check("t4 read addrs at i=10", 64'({ra0, rb0}), 64'({5'd10, 5'd21}));
    ctrlReset = 1'b1;
    @(posedge clock); #1;
    check("t4 status after reset", 64'(status(0)), 64'd0);
    check("t4 ports after reset",  64'(ports(0)),  64'd0);
    check("t4 writes drained", 64'(q0.size()), 64'd0);
    ctrlReset = 1'b0;
    runDut(0, 1'b0, 1'b0, cyc);
    check("t4 run after reset", 64'(status(0)), 64'(CLEAN));

    // Register 3 left dirty before the run.
    runDut(0, 1'b0, 1'b1, cyc);
    check("t6 dirty reg3", 64'(status(0)), 64'(T6_EXP));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
Name: regfile_bist

Overview:
- Self-test initiator for the 32x32 register file.
- Drives the regfile write port and both read ports, walks a data pattern through every register, reads it back, and compares.
- Reports pass/fail, error count and first failing register.
- Sits beside the regfile; muxed onto its ports during bring-up or post-reset self-test.

Parameters:
- PATTERN_MODE, 0, data for register i: 0 = 32'b1<<i; 1 = i zero-extended; 2 = ~(32'b1<<i)
- READ_LATENCY, 1, cycles from driving read address to sampling read data (1..4)

Ports:
- clock  in  1  system clock, all state on rising edge
- ctrl_reset  in  1  synchronous active-high reset
- start  in  1  level/pulse; begins a run when sampled high in IDLE or DONE
- ctrl_writeEn  out  1  regfile write enable
- ctrl_writeReg  out  5  regfile write address
- data_writeReg  out  32  regfile write data
- ctrl_readRegA  out  5  read address port A
- ctrl_readRegB  out  5  read address port B
- data_readRegA  in  32  read data port A
- data_readRegB  in  32  read data port B
- busy  out  1  run in progress
- done  out  1  run finished; sticky until next start
- pass  out  1  valid when done; 1 iff error_count==0
- error_count  out  8  mismatches this run (max 128, never wraps)
- fail_valid  out  1  at least one mismatch recorded
- fail_reg  out  5  address of first mismatch (port A checked before port B on the same cycle)

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; index 0. Applies mid-run: ctrl_writeEn low from the next edge, run abandoned, no done.
- FSM: IDLE -> WRITE -> RADDR -> RWAIT -> RCHECK -> DONE.
- IDLE: start=1 -> WRITE; clear error_count, fail_valid, fail_reg, pass; busy=1 next cycle.
- WRITE: one register per cycle, i=0..31.
  - ctrl_writeEn=1, ctrl_writeReg=i, data_writeReg=pattern(i).
  - After i=31: ctrl_writeEn=0 on the next cycle, index=0 -> RADDR.
- RADDR: ctrl_readRegA=i, ctrl_readRegB=31-i (exercises port independence). Addresses are held until the next RADDR.
- RWAIT: count READ_LATENCY-1 cycles. READ_LATENCY=1 skips RWAIT.
- RCHECK: expected value is 0 for address 0, otherwise pattern(addr).
  - Compare A against exp(i) and B against exp(31-i) using exact 4-state equality in simulation.
  - Each mismatch adds 1 to error_count; both ports failing adds 2.
  - On the first mismatch only, set fail_valid=1 and capture fail_reg.
  - i<31 -> i+1, RADDR; else DONE.
- DONE: busy=0, done=1, pass=(error_count==0). start=1 restarts (-> WRITE path via IDLE clear), done drops.
- start while busy is ignored. start held high continuously re-runs back-to-back, one IDLE/clear cycle between runs.
- Run length, cycles from start sample to done: 1 + 32 + 32*(READ_LATENCY+1).
- The regfile's data_writeReg/ctrl_writeReg are don't-care when ctrl_writeEn=0; the block still drives them 0.

Optional Feature:
- REGFILE_BIST_RESET_CHECK_EN defined: a PRECHECK read pass (same RADDR/RWAIT/RCHECK timing, expected 0 everywhere) runs before WRITE. This verifies regfile reset clearing. Errors accumulate into the same counters; worst case 128.
- Undefined: IDLE goes directly to WRITE; run length per formula above.

Decomposition:
- regfile_bist_pkg:
  - NUM_REGS=32, ADDR_W=5, DATA_W=32, ERR_W=8
  - state enum (IDLE, PRECHECK, WRITE, RADDR, RWAIT, RCHECK, DONE)
  - pattern(mode, addr) function
- Sub-module regfile_bist_cmp: registered dual-port comparator producing mismatch_a, mismatch_b and first-fail capture.

Test Plan:
1. Correct regfile, PATTERN_MODE=0, READ_LATENCY=1, start pulse -> done after 97 cycles; pass=1, error_count=0, fail_valid=0; writes observed 0x00000001..0x80000000.
2. Faulty regfile where reg 0 stores writes (reads 0x1) -> error_count=2 (A at i=0, B at i=31), fail_valid=1, fail_reg=0, pass=0.
3. Regfile with bit 7 of reg 5 stuck-at-1, PATTERN_MODE=1 -> error_count=2, fail_reg=5.
4. ctrl_reset asserted at RCHECK of i=10 -> next cycle busy=0, ctrl_writeEn=0, all outputs 0, done=0; a following start completes with pass=1.
5. start re-pulsed while busy -> ignored, single run. start after done -> done drops next cycle, second run matches first.
6. With REGFILE_BIST_RESET_CHECK_EN, reg 3 preloaded 0xFFFFFFFF, no regfile reset -> precheck errors=2, fail_reg=3; run length 1+64+32+64=161 cycles.
